seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Parametrised multiplexed seven-segment display driver; next generation of the board-level `driver` display path.
- Takes a binary value from the core (register or debug tap) and shows it on the board display. Supports hex or decimal rendering.
- Decimal rendering uses a sequential double-dabble converter. Also provides leading-zero blanking and overflow indication.
- Time-multiplexes NUM_DIGITS common-anode digits at a configurable refresh rate.

Parameters:
- NUM_DIGITS, 4, number of display digits; min 1.
- BIN_W, 16, input value width. Constraint: BIN_W <= 4*NUM_DIGITS.
- REFRESH_DIV, 100000, clk_in cycles each digit stays enabled; min 1.

Ports:
- clk_in  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- value  in  BIN_W  binary value to display; sampled only on accepted load.
- mode  in  1  0 = hex, 1 = unsigned decimal; sampled with value.
- load  in  1  request capture of value/mode.
- blank_lz  in  1  1 = blank leading zero digits; live, not latched.
- busy  out  1  conversion in progress; load ignored while high.
- overflow  out  1  last committed decimal value exceeded NUM_DIGITS digits.
- seg  out  [0:6]  segments a..g (seg[0]=a, seg[6]=g), active-low.
- anode  out  NUM_DIGITS  digit enables, active-low, one-hot-zero.

Behaviour:
- Reset (rst_n=0 at a clock edge), applied unconditionally, including mid-conversion:
  - FSM=IDLE; busy=0; overflow=0; display digits all 0.
  - Scan index=0; refresh counter=0.
  - Outputs settle to anode=...1110 and seg=0000001.
- Load handshake:
  - load is accepted only when high at an edge with busy=0. An accepted load latches value and mode.
  - load while busy is dropped. There is no queue.
- FSM states:
  - IDLE -> COMMIT on an accepted hex load.
  - IDLE -> CONVERT on an accepted decimal load.
  - CONVERT runs exactly BIN_W cycles. Each cycle it adds 3 to every BCD nibble >=5, then shifts the binary MSB into the BCD scratch.
  - CONVERT -> COMMIT after the BIN_W-th shift.
  - COMMIT -> IDLE after 1 cycle.
- busy is registered and high in CONVERT and COMMIT. Accept at edge k gives:
  - hex: busy high for 1 cycle;
  - decimal: busy high for BIN_W+1 cycles.
- BCD scratch width is 4*BCD_DIGITS, where BCD_DIGITS = decimal digit count of 2^BIN_W-1 (5 for BIN_W=16).
- COMMIT updates the display digit register and overflow atomically on its closing edge:
  - Hex: digit i = value[4i+3:4i], zero-extended; overflow=0.
  - Decimal: digit i = BCD nibble i. overflow=1 if any BCD nibble >= NUM_DIGITS is nonzero.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - On terminal count, counter returns to 0 and scan index increments, wrapping NUM_DIGITS-1 -> 0.
  - REFRESH_DIV=1 advances the index every cycle.
  - Scanning never stalls for load, busy or COMMIT.
- Output decode (combinational from registered index/display/overflow):
  - anode bit[index]=0, all other bits 1. Index 0 is the rightmost, least-significant digit.
  - If overflow=1: seg=1111110 (dash) on every digit.
  - Else if blank_lz=1, index>0, and digit[index] and all higher digits are 0: seg=1111111.
  - Else: seg=hex glyph of digit[index] (0-F).
  - Digit 0 is never blanked.

Decomposition:
- Shared header `seg_defs.vh`:
  - 16 hex glyph constants, SEG_DASH, SEG_BLANK (active-low, a..g ordering);
  - FSM state encodings.
- Sub-module bin2bcd_seq:
  - Implements the CONVERT datapath: start/done, BIN_W/BCD_DIGITS parameters.
  - Keeps scan/decode logic separate and reusable by other display blocks.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=4, BIN_W=16):
- Reset and scan:
  - Stimulus: rst_n=0 for 2 cycles, then release.
  - Response: busy=0, overflow=0, seg=0000001 on every digit. anode cycles 1110,1101,1011,0111,1110, each for exactly 4 cycles.
- Hex BEEF:
  - Stimulus: mode=0, value=16'hBEEF, 1-cycle load.
  - Response: busy high 1 cycle. Then digit0 seg=0111000 (F), digits 1 and 2 seg=0110000 (E), digit3 seg=1100000 (b).
- Decimal 1234:
  - Stimulus: mode=1, load.
  - Response: busy high exactly 17 cycles. Then digit0..3 show 4 (1001100), 3, 2, 1; overflow=0.
- Blanking, decimal 7:
  - Stimulus: load decimal 7, blank_lz=1, then toggle blank_lz=0.
  - Response: with blank_lz=1, digit0 seg=0001111 and digits 1-3 seg=1111111. With blank_lz=0, digits 1-3 seg=0000001.
- Overflow:
  - Stimulus: load decimal 12345, then decimal 99.
  - Response: after the first load, overflow=1 and all digits 1111110. After the second load, overflow=0 and digits show 9, 9.
- Abort and ignore:
  - Stimulus: assert load with a new value while busy; separately, drop rst_n low mid-CONVERT.
  - Response: the load during busy has no effect on the result. After the reset edge, busy=0, display shows 0, and scan index=0.

Source files
------------

// File: rtl/seg_display_scan_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states, glyph
// table (active-low, a..g ordering) and a BCD sizing helper.
package seg_display_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Decimal digit count of 2^w-1, used to size the BCD scratch.
  function automatic int unsigned bcd_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int unsigned k = 0; k < 20; k++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_display_scan_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle,
// BIN_W steps after start.
module bin2bcd_seq #(
  parameter int unsigned BIN_W      = 16,
  parameter int unsigned BCD_DIGITS = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic                    running;
  logic [CNT_W-1:0]        cnt;
  logic [BIN_W-1:0]        shreg;
  logic [4*BCD_DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done = running && (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      shreg   <= '0;
      bcd     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      shreg   <= bin;
      bcd     <= '0;
    end else if (running) begin
      bcd   <= {adj[4*BCD_DIGITS-2:0], shreg[BIN_W-1]};
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed common-anode seven-segment driver with hex or decimal
// rendering, leading-zero blanking and decimal overflow indication.
module seg_display_scan
  import seg_display_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BIN_W       = 16,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      value,
  input  logic                  mode,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  overflow,
  output logic [0:6]            seg,
  output logic [NUM_DIGITS-1:0] anode
);

  localparam int unsigned BCD_DIGITS = bcd_digits(BIN_W);
  localparam int unsigned DISP_W     = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    mode_q;
  logic [DISP_W-1:0]       value_q;
  logic [DISP_W-1:0]       disp, disp_nxt;
  logic                    ovf_nxt;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [CNT_W-1:0]        rcnt;
  logic [IDX_W-1:0]        idx;
  logic [DISP_W-1:0]       upper;
  logic [3:0]              cur;

  assign accept = load && !busy;

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .start  (accept && mode),
    .bin    (value),
    .done   (conv_done),
    .bcd    (bcd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = mode ? ST_CONVERT : ST_COMMIT;
      ST_CONVERT: if (conv_done) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      mode_q  <= 1'b0;
      value_q <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      if (accept) begin
        mode_q  <= mode;
        value_q <= DISP_W'(value);
      end
    end
  end

  // BCD nibbles beyond the physical digit count only feed the overflow flag.
  always_comb begin
    disp_nxt = '0;
    ovf_nxt  = 1'b0;
    if (mode_q) begin
      for (int unsigned i = 0; i < NUM_DIGITS && i < BCD_DIGITS; i++)
        disp_nxt[4*i +: 4] = bcd[4*i +: 4];
      for (int unsigned i = NUM_DIGITS; i < BCD_DIGITS; i++)
        if (bcd[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
    end else begin
      disp_nxt = value_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      disp     <= '0;
      overflow <= 1'b0;
    end else if (state == ST_COMMIT) begin
      disp     <= disp_nxt;
      overflow <= ovf_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == CNT_W'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_comb begin
    upper = disp >> {idx, 2'b00};
    cur   = upper[3:0];
    anode = '1;
    anode[idx] = 1'b0;
    if (overflow)
      seg = SEG_DASH;
    else if (blank_lz && (idx != '0) && (upper == '0))
      seg = SEG_BLANK;
    else
      seg = hex_glyph(cur);
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan (NUM_DIGITS=4, BIN_W=16, REFRESH_DIV=4).
module tb_seg_display_scan;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        mode;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic        overflow;
  logic [0:6]  seg;
  logic [3:0]  anode;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  seg_display_scan #(
    .NUM_DIGITS  (4),
    .BIN_W       (16),
    .REFRESH_DIV (4)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .value    (value),
    .mode     (mode),
    .load     (load),
    .blank_lz (blank_lz),
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .anode    (anode)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic do_load(input logic m, input logic [15:0] v);
    @(negedge clk_in);
    mode  = m;
    value = v;
    load  = 1'b1;
    @(negedge clk_in);
    load  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic show_digit(input int i, input logic [6:0] exp, input string tag);
    logic [3:0] an_exp;
    int n;
    an_exp = ~(4'b0001 << i);
    n = 0;
    while (anode !== an_exp && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check($sformatf("%s_an%0d", tag, i), anode, an_exp);
    check($sformatf("%s_seg%0d", tag, i), seg, exp);
  endtask

  initial begin
    int nb;
    logic [3:0] an_exp;
    rst_n    = 1'b0;
    value    = '0;
    mode     = 1'b0;
    load     = 1'b0;
    blank_lz = 1'b0;

    // Reset and scan: each anode held exactly 4 cycles
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    for (int k = 0; k < 20; k++) begin
      an_exp = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("scan_an_%0d", k), anode, an_exp);
      check($sformatf("scan_seg_%0d", k), seg, 7'b0000001);
      @(negedge clk_in);
    end

    // Hex BEEF: busy for one cycle
    do_load(1'b0, 16'hBEEF);
    check("hex_busy1", busy, 1);
    @(negedge clk_in);
    check("hex_busy0", busy, 0);
    check("hex_ovf", overflow, 0);
    show_digit(0, 7'b0111000, "hex");
    show_digit(1, 7'b0110000, "hex");
    show_digit(2, 7'b0110000, "hex");
    show_digit(3, 7'b1100000, "hex");

    // Decimal 1234: busy for 17 cycles
    do_load(1'b1, 16'd1234);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk_in);
    end
    check("dec_busy_len", nb, 17);
    check("dec_ovf", overflow, 0);
    show_digit(0, 7'b1001100, "dec");
    show_digit(1, 7'b0000110, "dec");
    show_digit(2, 7'b0010010, "dec");
    show_digit(3, 7'b1001111, "dec");

    // Leading-zero blanking on decimal 7
    blank_lz = 1'b1;
    do_load(1'b1, 16'd7);
    wait_idle("blk_idle");
    show_digit(0, 7'b0001111, "blk1");
    show_digit(1, 7'b1111111, "blk1");
    show_digit(2, 7'b1111111, "blk1");
    show_digit(3, 7'b1111111, "blk1");
    blank_lz = 1'b0;
    show_digit(0, 7'b0001111, "blk0");
    show_digit(1, 7'b0000001, "blk0");
    show_digit(2, 7'b0000001, "blk0");
    show_digit(3, 7'b0000001, "blk0");

    // Overflow: 12345 needs five digits, 99 does not
    do_load(1'b1, 16'd12345);
    wait_idle("ovf_idle");
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) show_digit(i, 7'b1111110, "ovf");
    do_load(1'b1, 16'd99);
    wait_idle("ovf99_idle");
    check("ovf_clr", overflow, 0);
    show_digit(0, 7'b0000100, "d99");
    show_digit(1, 7'b0000100, "d99");
    show_digit(2, 7'b0000001, "d99");
    show_digit(3, 7'b0000001, "d99");

    // Load during busy is dropped
    do_load(1'b1, 16'd4321);
    repeat (3) @(negedge clk_in);
    check("ign_busy", busy, 1);
    value = 16'd9999;
    mode  = 1'b0;
    load  = 1'b1;
    @(negedge clk_in);
    load  = 1'b0;
    wait_idle("ign_idle");
    @(negedge clk_in);
    check("ign_busy_after", busy, 0);
    show_digit(0, 7'b1001111, "ign");
    show_digit(1, 7'b0010010, "ign");
    show_digit(2, 7'b0000110, "ign");
    show_digit(3, 7'b1001100, "ign");

    // Reset mid-CONVERT aborts and restarts the scan
    do_load(1'b1, 16'd5555);
    repeat (4) @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    check("abrt_busy", busy, 0);
    check("abrt_ovf", overflow, 0);
    for (int k = 0; k < 5; k++) begin
      an_exp = (k < 4) ? 4'b1110 : 4'b1101;
      check($sformatf("abrt_an_%0d", k), anode, an_exp);
      check($sformatf("abrt_seg_%0d", k), seg, 7'b0000001);
      @(negedge clk_in);
    end
    repeat (25) @(negedge clk_in);
    check("abrt_busy_late", busy, 0);
    for (int i = 0; i < 4; i++) show_digit(i, 7'b0000001, "abrt");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
